// File: rtl/vedic_pp_sum_seq.sv
// Folds the four HALF_W x HALF_W partial products into the 2*PP_W product with three adds on one shared registered adder.
// Latency 1+3*(1+L) cycles for adder latency L; start is ignored while busy. VEDIC_SEQ_ERR_EN adds a per-add adder_done timeout.
module vedic_pp_sum_seq #(
    parameter int HALF_W  = 16,
    parameter int TIMEOUT = 15,
    localparam int PP_W   = 2 * HALF_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [PP_W-1:0]   pp0,
    input  logic [PP_W-1:0]   pp1,
    input  logic [PP_W-1:0]   pp2,
    input  logic [PP_W-1:0]   pp3,
    output logic              busy,
    output logic              done,
    output logic [2*PP_W-1:0] product_out,
    output logic [PP_W-1:0]   adder_a,
    output logic [PP_W-1:0]   adder_b,
    output logic              adder_do,
    input  logic [PP_W:0]     adder_res,
    input  logic              adder_done,
    output logic              err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        step_q, step_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [PP_W-1:0]   pp0_q, pp1_q, pp2_q, pp3_q;
    logic [PP_W-1:0]   s1_q;
    logic [PP_W:0]     s2_q;
    logic [2*PP_W-1:0] product_q;
    logic              timeout;

`ifdef VEDIC_SEQ_ERR_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] cnt_q;

    // Counter restarts on every entry to WAIT since it is held at zero in ISSUE.
    assign timeout = (state_q == S_WAIT) && !adder_done && (cnt_q == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else if (state_q != S_WAIT) begin
            cnt_q <= '0;
        end else if (!adder_done) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_ISSUE;
                    step_d  = 2'd0;
                    busy_d  = 1'b1;
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (adder_done) begin
                    if (step_q == 2'd2) begin
                        state_d = S_IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_ISSUE;
                        step_d  = step_q + 2'd1;
                    end
                end else if (timeout) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    err_d   = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            step_q  <= 2'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // s1 never exceeds PP_W bits, so its carry bit is dropped at capture.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pp0_q     <= '0;
            pp1_q     <= '0;
            pp2_q     <= '0;
            pp3_q     <= '0;
            s1_q      <= '0;
            s2_q      <= '0;
            product_q <= '0;
        end else begin
            if (state_q == S_IDLE && start) begin
                pp0_q <= pp0;
                pp1_q <= pp1;
                pp2_q <= pp2;
                pp3_q <= pp3;
            end
            if (state_q == S_WAIT && adder_done) begin
                case (step_q)
                    2'd0:    s1_q <= adder_res[PP_W-1:0];
                    2'd1:    s2_q <= adder_res;
                    2'd2:    product_q <= {adder_res[PP_W-1:0], s2_q[HALF_W-1:0], pp0_q[HALF_W-1:0]};
                    default: ;
                endcase
            end
        end
    end

    // Operands depend only on step and captured state, so they stay stable throughout WAIT.
    always_comb begin
        adder_a = '0;
        adder_b = '0;
        if (state_q != S_IDLE) begin
            case (step_q)
                2'd0: begin
                    adder_a = pp1_q;
                    adder_b = {{HALF_W{1'b0}}, pp0_q[PP_W-1:HALF_W]};
                end
                2'd1: begin
                    adder_a = pp2_q;
                    adder_b = s1_q;
                end
                default: begin
                    adder_a = pp3_q;
                    adder_b = {{(HALF_W-1){1'b0}}, s2_q[PP_W:HALF_W]};
                end
            endcase
        end
    end

    assign adder_do    = (state_q == S_ISSUE);
    assign busy        = busy_q;
    assign done        = done_q;
    assign product_out = product_q;
    assign err         = err_q;

endmodule
